sdram_responder: RTL and testbench

//  Synthesizable single-device SDR SDRAM emulator: the chip side of the command bus our sdram controller drives.

---
 rtl/sdram_responder_if.sv | 27 ++
 rtl/sdram_responder.sv | 167 ++++++++++++++++
 tb/tb_sdram_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_responder_if.sv
// Command/data bus between an SDR SDRAM controller (master) and the sdram_responder
// chip model (slave), plus the responder's status lines.
interface sdram_responder_if;
    logic        ramCs;
    logic        ramRas;
    logic        ramCas;
    logic        ramWe;
    logic [1:0]  ramDqm;
    logic [1:0]  ramBA;
    logic [12:0] ramA;
    logic [15:0] dqIn;
    logic [15:0] dqOut;
    logic [1:0]  dqOe;
    logic        ready;
    logic [1:0]  casLatency;
    logic        protoError;

    modport master (
        output ramCs, ramRas, ramCas, ramWe, ramDqm, ramBA, ramA, dqIn,
        input  dqOut, dqOe, ready, casLatency, protoError
    );

    modport slave (
        input  ramCs, ramRas, ramCas, ramWe, ramDqm, ramBA, ramA, dqIn,
        output dqOut, dqOe, ready, casLatency, protoError
    );
endinterface

// File: rtl/sdram_responder.sv
// Single-device SDR SDRAM emulator: decodes the command bus, runs the init sequence,
// tracks four banks, serves CAS-latency reads from a block RAM and flags protocol errors.
//
// state         | meaning
// st_wait_pre   | after reset, waiting for PRECHARGE all (A10=1)
// st_ref0       | waiting for first REFRESH
// st_ref1       | waiting for second REFRESH
// st_wait_lmr   | waiting for a valid LOAD MODE REGISTER (extra REFRESH allowed)
// st_ready      | mode valid, normal command decode
module sdram_responder #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 8,
    parameter int TRCD     = 2
) (
    input logic             clock,
    input logic             reset,
    sdram_responder_if.slave bus
);
    localparam int AW    = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;
    localparam int TW    = (TRCD > 1) ? $clog2(TRCD) : 1;

    typedef enum logic [2:0] {
        st_wait_pre, st_ref0, st_ref1, st_wait_lmr, st_ready
    } state_t;

    state_t state_q, state_d;

    logic [3:0]          open_q;
    logic [ROW_BITS-1:0] row_q  [4];
    logic [TW-1:0]       trcd_q [4];
    logic [1:0]          cl_q;
    logic                perr_q;
    logic                p1_vld, p2_vld;
    logic [1:0]          p1_oe, p2_oe;
    logic [15:0]         p1_data, p2_data;
    logic [15:0]         mem [DEPTH];

    logic       sel;
    logic [2:0] rcw;
    logic       is_nop, is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
    logic       a10, mode_ok, any_open, rdy;
    logic       do_act, do_rd, do_wr, do_pre, do_lmr, set_err;
    logic [1:0] ba;
    logic [AW-1:0] addr;

    assign sel      = !bus.ramCs;
    assign rcw      = {bus.ramRas, bus.ramCas, bus.ramWe};
    assign is_nop   = !sel || rcw == 3'b111;
    assign is_act   = sel && rcw == 3'b011;
    assign is_rd    = sel && rcw == 3'b101;
    assign is_wr    = sel && rcw == 3'b100;
    assign is_pre   = sel && rcw == 3'b010;
    assign is_ref   = sel && rcw == 3'b001;
    assign is_lmr   = sel && rcw == 3'b000;
    assign a10      = bus.ramA[10];
    assign ba       = bus.ramBA;
    assign mode_ok  = bus.ramA[2:0] == 3'b000 && bus.ramA[5];
    assign any_open = |open_q;
    assign addr     = {ba, row_q[ba], bus.ramA[COL_BITS-1:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= st_wait_pre;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            st_wait_pre: if (is_pre && a10)          state_d = st_ref0;
            st_ref0:     if (is_ref)                 state_d = st_ref1;
            st_ref1:     if (is_ref)                 state_d = st_wait_lmr;
            st_wait_lmr: if (is_lmr && mode_ok)      state_d = st_ready;
            default:                                 state_d = st_ready;
        endcase
    end

    // Before ready, anything not advancing the init sequence is an ignored error.
    always_comb begin
        rdy     = state_q == st_ready;
        do_act  = rdy && is_act && !open_q[ba];
        do_rd   = rdy && is_rd;
        do_wr   = rdy && is_wr;
        do_pre  = rdy && is_pre;
        do_lmr  = is_lmr && mode_ok && (rdy ? !any_open : state_q == st_wait_lmr);
        set_err = 1'b0;
        if (rdy) begin
            set_err = (is_act && open_q[ba])
                   || ((is_rd || is_wr) && (!open_q[ba] || trcd_q[ba] != '0))
                   || (is_ref && any_open)
                   || (is_lmr && (any_open || !mode_ok));
        end else if (!is_nop) begin
            set_err = !((state_q == st_wait_pre && is_pre && a10)
                     || (state_q == st_ref0 && is_ref)
                     || (state_q == st_ref1 && is_ref)
                     || (state_q == st_wait_lmr && (is_ref || (is_lmr && mode_ok))));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            open_q <= '0;
            for (int b = 0; b < 4; b++) begin
                row_q[b]  <= '0;
                trcd_q[b] <= '0;
            end
            cl_q   <= 2'd2;
            perr_q <= 1'b0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (trcd_q[b] != '0) trcd_q[b] <= trcd_q[b] - 1'b1;
            if (do_act) begin
                open_q[ba] <= 1'b1;
                row_q[ba]  <= bus.ramA[ROW_BITS-1:0];
                trcd_q[ba] <= TW'(TRCD - 1);
            end
            if (do_pre) begin
                if (a10) open_q <= '0;
                else     open_q[ba] <= 1'b0;
            end
            if ((do_rd || do_wr) && a10) open_q[ba] <= 1'b0;
            if (do_lmr)  cl_q <= bus.ramA[5:4];
            if (set_err) perr_q <= 1'b1;
        end
    end

    // Read data is captured at the command edge, so later writes cannot disturb it.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            if (!bus.ramDqm[0]) mem[addr][7:0]  <= bus.dqIn[7:0];
            if (!bus.ramDqm[1]) mem[addr][15:8] <= bus.dqIn[15:8];
        end
        if (do_rd) p1_data <= mem[addr];
        p2_data <= p1_data;
    end

    logic [1:0]  oe_sel;
    logic [15:0] data_sel;

    always_comb begin
        oe_sel   = (cl_q == 2'd3) ? (p2_vld ? p2_oe : 2'b00) : (p1_vld ? p1_oe : 2'b00);
        data_sel = (cl_q == 2'd3) ? p2_data : p1_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p1_vld     <= 1'b0;
            p2_vld     <= 1'b0;
            p1_oe      <= 2'b00;
            p2_oe      <= 2'b00;
            bus.dqOut  <= '0;
            bus.dqOe   <= 2'b00;
        end else begin
            p1_vld    <= do_rd;
            p1_oe     <= ~bus.ramDqm;
            p2_vld    <= p1_vld;
            p2_oe     <= p1_oe;
            bus.dqOe  <= oe_sel;
            bus.dqOut <= {oe_sel[1] ? data_sel[15:8] : 8'h00,
                          oe_sel[0] ? data_sel[7:0]  : 8'h00};
        end
    end

    assign bus.ready      = state_q == st_ready;
    assign bus.casLatency = cl_q;
    assign bus.protoError = perr_q;
endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, CL2/CL3 reads, byte masks, error flags, reset.
module tb_sdram_responder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clock = ~clock;

    sdram_responder_if bus ();

    sdram_responder #(.ROW_BITS(4), .COL_BITS(8), .TRCD(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one command for one clock; returns at the falling edge after it is sampled.
    task automatic issue(input logic cs_n, input logic [2:0] rcw, input logic [1:0] ba,
                         input logic [12:0] a, input logic [15:0] d, input logic [1:0] dqm);
        bus.ramCs  = cs_n;
        {bus.ramRas, bus.ramCas, bus.ramWe} = rcw;
        bus.ramBA  = ba;
        bus.ramA   = a;
        bus.dqIn   = d;
        bus.ramDqm = dqm;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic nop();                       issue(1'b1, 3'b111, 2'd0, 13'h0, 16'h0, 2'b00); endtask
    task automatic act(input logic [1:0] ba, input logic [12:0] row);
        issue(1'b0, 3'b011, ba, row, 16'h0, 2'b00);
    endtask
    task automatic rd(input logic [1:0] ba, input logic [12:0] col, input logic [1:0] dqm);
        issue(1'b0, 3'b101, ba, col, 16'h0, dqm);
    endtask
    task automatic wr(input logic [1:0] ba, input logic [12:0] col, input logic [15:0] d,
                      input logic [1:0] dqm);
        issue(1'b0, 3'b100, ba, col, d, dqm);
    endtask
    task automatic pre(input logic [1:0] ba, input logic all);
        issue(1'b0, 3'b010, ba, all ? 13'h400 : 13'h000, 16'h0, 2'b00);
    endtask
    task automatic refc();                      issue(1'b0, 3'b001, 2'd0, 13'h0, 16'h0, 2'b00); endtask
    task automatic lmr(input logic [12:0] a);   issue(1'b0, 3'b000, 2'd0, a, 16'h0, 2'b00); endtask

    task automatic init_seq();
        pre(2'd0, 1'b1);
        refc();
        refc();
        lmr(13'h020);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        nop();
        nop();
        reset = 1'b1;
    endtask

    initial begin
        bus.ramCs = 1'b1; bus.ramRas = 1'b1; bus.ramCas = 1'b1; bus.ramWe = 1'b1;
        bus.ramBA = '0; bus.ramA = '0; bus.dqIn = '0; bus.ramDqm = '0;
        repeat (2) @(negedge clock);
        check_val("rst_ready", bus.ready, 1'b0);
        check_val("rst_dqoe", bus.dqOe, 2'b00);
        check_val("rst_dqout", bus.dqOut, 16'h0000);
        check_val("rst_cl", bus.casLatency, 2'd2);
        check_val("rst_perr", bus.protoError, 1'b0);
        reset = 1'b1;
        nop();

        init_seq();
        check_val("init_ready", bus.ready, 1'b1);
        check_val("init_cl", bus.casLatency, 2'd2);
        check_val("init_perr", bus.protoError, 1'b0);

        // CL2 write then read after re-activating the row
        act(2'd1, 13'd3);
        nop(); nop();
        wr(2'd1, 13'h15, 16'hBEEF, 2'b00);
        pre(2'd1, 1'b0);
        act(2'd1, 13'd3);
        nop();
        rd(2'd1, 13'h15, 2'b00);
        nop();
        check_val("cl2_data", bus.dqOut, 16'hBEEF);
        check_val("cl2_oe", bus.dqOe, 2'b11);
        nop();
        check_val("cl2_oe_off", bus.dqOe, 2'b00);
        check_val("cl2_perr", bus.protoError, 1'b0);

        // Byte masks on write and read
        wr(2'd1, 13'h20, 16'h1234, 2'b00);
        wr(2'd1, 13'h20, 16'hABCD, 2'b01);
        rd(2'd1, 13'h20, 2'b00);
        nop();
        check_val("dqm_wr", bus.dqOut, 16'hAB34);
        rd(2'd1, 13'h20, 2'b10);
        nop();
        check_val("dqm_rd_oe", bus.dqOe, 2'b01);
        check_val("dqm_rd_data", bus.dqOut, 16'h0034);

        // Write behind a pending read leaves the read data intact
        rd(2'd1, 13'h15, 2'b00);
        wr(2'd1, 13'h15, 16'h5555, 2'b00);
        check_val("wr_behind_rd", bus.dqOut, 16'hBEEF);
        rd(2'd1, 13'h15, 2'b00);
        nop();
        check_val("wr_after_rd", bus.dqOut, 16'h5555);

        // CL3 streaming
        pre(2'd0, 1'b1);
        lmr(13'h030);
        check_val("cl3_mode", bus.casLatency, 2'd3);
        act(2'd2, 13'd5);
        nop();
        for (int i = 0; i < 4; i++) wr(2'd2, 13'(i), 16'h1000 + 16'(i), 2'b00);
        rd(2'd2, 13'd0, 2'b00);
        rd(2'd2, 13'd1, 2'b00);
        rd(2'd2, 13'd2, 2'b00);
        check_val("cl3_w0", bus.dqOut, 16'h1000);
        rd(2'd2, 13'd3, 2'b00);
        check_val("cl3_w1", bus.dqOut, 16'h1001);
        nop();
        check_val("cl3_w2", bus.dqOut, 16'h1002);
        nop();
        check_val("cl3_w3", bus.dqOut, 16'h1003);
        check_val("cl3_oe", bus.dqOe, 2'b11);
        nop();
        check_val("cl3_oe_off", bus.dqOe, 2'b00);
        check_val("cl3_perr", bus.protoError, 1'b0);

        // Reset while a CL3 read is in flight
        rd(2'd2, 13'd0, 2'b00);
        nop();
        reset = 1'b0;
        #1;
        check_val("mid_rst_oe", bus.dqOe, 2'b00);
        check_val("mid_rst_ready", bus.ready, 1'b0);
        check_val("mid_rst_cl", bus.casLatency, 2'd2);
        @(negedge clock);
        reset = 1'b1;
        nop(); nop();
        check_val("post_rst_oe", bus.dqOe, 2'b00);
        refc();
        check_val("waitpre_ref_err", bus.protoError, 1'b1);
        init_seq();
        check_val("reinit_ready", bus.ready, 1'b1);

        // Memory survives reset
        apply_reset();
        check_val("rst_perr_clr", bus.protoError, 1'b0);
        init_seq();
        act(2'd2, 13'd5);
        nop();
        rd(2'd2, 13'd1, 2'b00);
        nop();
        check_val("mem_kept", bus.dqOut, 16'h1001);
        check_val("mem_kept_perr", bus.protoError, 1'b0);

        // Protocol errors
        rd(2'd0, 13'd0, 2'b00);
        check_val("err_rd_closed", bus.protoError, 1'b1);

        apply_reset();
        init_seq();
        act(2'd0, 13'd1);
        rd(2'd0, 13'd0, 2'b00);
        check_val("err_trcd", bus.protoError, 1'b1);

        apply_reset();
        init_seq();
        lmr(13'h031);
        check_val("err_bl_perr", bus.protoError, 1'b1);
        check_val("err_bl_cl", bus.casLatency, 2'd2);

        apply_reset();
        init_seq();
        act(2'd3, 13'd2);
        act(2'd3, 13'd4);
        check_val("err_act_open", bus.protoError, 1'b1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
